// File: rtl/hqc_rm_pkg.sv
// Shared RM(1,7) definitions for the HQC inner-code datapath: sizes, per-level constants,
// FSM state type and the byte-to-codeword encoder.
package hqc_rm_pkg;

  localparam int unsigned RM_N = 128;
  localparam int unsigned RM_K = 8;

  typedef enum logic [1:0] {HQC_128, HQC_192, HQC_256} hqc_level_t;

  typedef enum logic [1:0] {IDLE, FILL, EMIT, DONE} rm_state_t;

  function automatic int unsigned hqc_n1(input hqc_level_t lvl);
    case (lvl)
      HQC_192: return 56;
      HQC_256: return 90;
      default: return 46;
    endcase
  endfunction

  function automatic int unsigned hqc_mult(input hqc_level_t lvl);
    case (lvl)
      HQC_192: return 5;
      HQC_256: return 5;
      default: return 3;
    endcase
  endfunction

  // Bit 7 selects the all-ones row; bits 6:0 select the rows j[6:0].
  function automatic logic [RM_N-1:0] rm_encode_byte(input logic [RM_K-1:0] b);
    logic [RM_N-1:0] cw;
    cw = '0;
    for (int unsigned j = 0; j < RM_N; j++) begin
      cw[j] = b[7] ^ (^(b[6:0] & j[6:0]));
    end
    return cw;
  endfunction

endpackage

// File: rtl/rm_dup_encoder_stream_if.sv
// Byte input and codeword output handshakes of the duplicated RM encoder.
interface rm_dup_encoder_stream_if #(parameter int unsigned OUT_W = 128);
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [OUT_W-1:0] cdw_out;
  logic             cdw_valid;
  logic             cdw_ready;

  modport master (
    input  byte_in, byte_valid, cdw_ready,
    output byte_ready, cdw_out, cdw_valid
  );

  modport slave (
    output byte_in, byte_valid, cdw_ready,
    input  byte_ready, cdw_out, cdw_valid
  );
endinterface

// File: rtl/rm_word_sel.sv
// Selects OUT_W-bit word number word_idx out of a 128-bit RM codeword.
module rm_word_sel
  import hqc_rm_pkg::*;
#(
  parameter int unsigned OUT_W   = 128,
  parameter int unsigned WORD_CW = 1
) (
  input  logic [RM_N-1:0]    cw,
  input  logic [WORD_CW-1:0] word_idx,
  output logic [OUT_W-1:0]   word
);

  always_comb begin
    word = OUT_W'(cw >> (int'(word_idx) * OUT_W));
  end

endmodule

// File: rtl/rm_dup_encoder_stream.sv
// Streaming duplicated RM(1,7) encoder: one byte in, MULTIPLICITY copies of its 128-bit
// codeword out as OUT_W-bit words, with a one-byte prefetch to avoid bubbles.
module rm_dup_encoder_stream
  import hqc_rm_pkg::*;
#(
  parameter int unsigned N1           = hqc_n1(HQC_128),
  parameter int unsigned MULTIPLICITY = hqc_mult(HQC_128),
  parameter int unsigned OUT_W        = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  rm_dup_encoder_stream_if.master bus,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned WPC     = RM_N / OUT_W;
  localparam int unsigned BYTE_CW = $clog2(N1 + 1);
  localparam int unsigned COPY_CW = (MULTIPLICITY > 1) ? $clog2(MULTIPLICITY) : 1;
  localparam int unsigned WORD_CW = (WPC > 1) ? $clog2(WPC) : 1;

  localparam logic [BYTE_CW-1:0] N1_V      = BYTE_CW'(N1);
  localparam logic [COPY_CW-1:0] LAST_COPY = COPY_CW'(MULTIPLICITY - 1);
  localparam logic [WORD_CW-1:0] LAST_WORD = WORD_CW'(WPC - 1);

  if (!(OUT_W == 32 || OUT_W == 64 || OUT_W == 128) || MULTIPLICITY < 1) begin : g_param_check
    $error("rm_dup_encoder_stream: OUT_W must be 32/64/128 and MULTIPLICITY >= 1");
  end

  rm_state_t          state, state_nxt;
  logic [BYTE_CW-1:0] byte_cnt, byte_cnt_nxt;
  logic [COPY_CW-1:0] copy_cnt, copy_cnt_nxt;
  logic [WORD_CW-1:0] word_cnt, word_cnt_nxt;
  logic [RM_N-1:0]    out_reg, out_reg_nxt;
  logic [7:0]         hold_byte, hold_byte_nxt;
  logic               hold_full, hold_full_nxt;

  logic               byte_rdy, cdw_vld, byte_xfer, last_xfer, more_bytes;
  logic [RM_N-1:0]    enc_cw;
  logic [OUT_W-1:0]   cdw_word;

  // Single encoder: the held byte has priority, it is only present when byte_ready is low.
  always_comb begin
    enc_cw = rm_encode_byte(hold_full ? hold_byte : bus.byte_in);
  end

  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    copy_cnt_nxt  = copy_cnt;
    word_cnt_nxt  = word_cnt;
    out_reg_nxt   = out_reg;
    hold_byte_nxt = hold_byte;
    hold_full_nxt = hold_full;
    busy          = 1'b0;
    done          = 1'b0;
    byte_rdy      = 1'b0;
    cdw_vld       = 1'b0;
    more_bytes    = byte_cnt < N1_V;
    byte_xfer     = 1'b0;
    last_xfer     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt     = FILL;
          byte_cnt_nxt  = '0;
          copy_cnt_nxt  = '0;
          word_cnt_nxt  = '0;
          hold_full_nxt = 1'b0;
        end
      end
      FILL: begin
        busy     = 1'b1;
        byte_rdy = more_bytes;
        if (bus.byte_valid && byte_rdy) begin
          out_reg_nxt  = enc_cw;
          byte_cnt_nxt = byte_cnt + 1'b1;
          copy_cnt_nxt = '0;
          word_cnt_nxt = '0;
          state_nxt    = EMIT;
        end
      end
      EMIT: begin
        busy      = 1'b1;
        cdw_vld   = 1'b1;
        byte_rdy  = !hold_full && more_bytes;
        byte_xfer = bus.byte_valid && byte_rdy;
        last_xfer = bus.cdw_ready && (word_cnt == LAST_WORD) && (copy_cnt == LAST_COPY);
        if (byte_xfer) byte_cnt_nxt = byte_cnt + 1'b1;
        if (bus.cdw_ready) begin
          if (word_cnt != LAST_WORD) begin
            word_cnt_nxt = word_cnt + 1'b1;
          end else begin
            word_cnt_nxt = '0;
            copy_cnt_nxt = (copy_cnt != LAST_COPY) ? copy_cnt + 1'b1 : '0;
          end
        end
        // Next codeword comes from the holding reg, or straight from the input if it lands now.
        if (last_xfer) begin
          if (hold_full || byte_xfer) begin
            out_reg_nxt   = enc_cw;
            hold_full_nxt = 1'b0;
          end else if (more_bytes) begin
            state_nxt = FILL;
          end else begin
            state_nxt = DONE;
          end
        end else if (byte_xfer) begin
          hold_byte_nxt = bus.byte_in;
          hold_full_nxt = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      copy_cnt  <= '0;
      word_cnt  <= '0;
      out_reg   <= '0;
      hold_byte <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      copy_cnt  <= copy_cnt_nxt;
      word_cnt  <= word_cnt_nxt;
      out_reg   <= out_reg_nxt;
      hold_byte <= hold_byte_nxt;
      hold_full <= hold_full_nxt;
    end
  end

  rm_word_sel #(
    .OUT_W  (OUT_W),
    .WORD_CW(WORD_CW)
  ) u_word_sel (
    .cw      (out_reg),
    .word_idx(word_cnt),
    .word    (cdw_word)
  );

  assign bus.byte_ready = byte_rdy;
  assign bus.cdw_valid  = cdw_vld;
  assign bus.cdw_out    = cdw_word;

endmodule

// File: tb/tb_rm_dup_encoder_stream.sv
// Directed bench for rm_dup_encoder_stream: table of byte/codeword pairs plus
// hand-written sequences for the 32-bit x5 case and mid-job reset.
module tb_rm_dup_encoder_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, busy_a, done_a, busy_b, done_b;

  rm_dup_encoder_stream_if #(.OUT_W(128)) ifa ();
  rm_dup_encoder_stream_if #(.OUT_W(32))  ifb ();

  rm_dup_encoder_stream #(.N1(4), .MULTIPLICITY(3), .OUT_W(128)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(ifa), .busy(busy_a), .done(done_a)
  );

  rm_dup_encoder_stream #(.N1(1), .MULTIPLICITY(5), .OUT_W(32)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(ifb), .busy(busy_b), .done(done_b)
  );

  typedef struct {
    logic [7:0]   b;
    logic [127:0] cw;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] job_bytes[4];
  int         vec_cnt = 0;
  int         err_cnt = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] cw_of(input logic [7:0] b);
    for (int i = 0; i < 8; i++) if (vecs[i].b == b) return vecs[i].cw;
    return '0;
  endfunction

  // One N1=4 job on dut_a; words 3k..3k+2 must all carry the codeword of byte k.
  task automatic run_job_a(input int ready_pct, input bit valid_always, input bit bubble_chk);
    int           bi = 0, wi = 0, last_x = -10;
    bit           prev_stall = 0, got_done = 0;
    logic [127:0] prev_out = '0;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    for (int cyc = 0; cyc < 600 && !got_done; cyc++) begin
      ifa.byte_valid = (bi < 4) && (valid_always || ($urandom_range(0, 1) == 1));
      ifa.byte_in    = ifa.byte_valid ? job_bytes[bi % 4] : 8'($urandom);
      ifa.cdw_ready  = ($urandom_range(0, 99) < ready_pct);
      start_a        = (cyc == 6);
      #1;
      if (done_a) begin
        check("done_timing", 128'(cyc), 128'(last_x + 1));
        check("word_count", 128'(wi), 128'd12);
        check("bytes_taken", 128'(bi), 128'd4);
        got_done = 1;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 128'(ifa.cdw_valid), 128'd1);
          check("stall_hold", ifa.cdw_out, prev_out);
        end
        if (bubble_chk && wi > 0 && wi < 12) check("no_bubble", 128'(ifa.cdw_valid), 128'd1);
        if (bi == 4) check("byte_ready_low", 128'(ifa.byte_ready), 128'd0);
        if (ifa.cdw_valid && ifa.cdw_ready) begin
          check("cdw_word", ifa.cdw_out, cw_of(job_bytes[(wi / 3) % 4]));
          wi++;
          last_x = cyc;
        end
        prev_stall = ifa.cdw_valid && !ifa.cdw_ready;
        prev_out   = ifa.cdw_out;
        if (ifa.byte_valid && ifa.byte_ready) bi++;
        @(negedge clk);
      end
    end
    start_a        = 1'b0;
    ifa.byte_valid = 1'b0;
    if (!got_done) begin
      check("job_a_timeout", 128'(got_done), 128'd1);
    end else begin
      start_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_a = 1'b0;
      check("start_in_done_ignored", 128'(busy_a), 128'd0);
      check("done_one_cycle", 128'(done_a), 128'd0);
    end
  endtask

  initial begin
    int  wi, bi, last_x;
    bit  got_done;

    vecs[0] = '{8'h00, 128'h0};
    vecs[1] = '{8'h80, 128'hffffffff_ffffffff_ffffffff_ffffffff};
    vecs[2] = '{8'h01, 128'haaaaaaaa_aaaaaaaa_aaaaaaaa_aaaaaaaa};
    vecs[3] = '{8'h02, 128'hcccccccc_cccccccc_cccccccc_cccccccc};
    vecs[4] = '{8'h20, 128'hffffffff_00000000_ffffffff_00000000};
    vecs[5] = '{8'h40, 128'hffffffff_ffffffff_00000000_00000000};
    vecs[6] = '{8'h81, 128'h55555555_55555555_55555555_55555555};
    vecs[7] = '{8'h03, 128'h66666666_66666666_66666666_66666666};

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ifa.byte_in = '0; ifa.byte_valid = 1'b0; ifa.cdw_ready = 1'b0;
    ifb.byte_in = '0; ifb.byte_valid = 1'b0; ifb.cdw_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cdw_out", ifa.cdw_out, 128'h0);
    check("rst_cdw_valid", 128'(ifa.cdw_valid), 128'd0);
    check("rst_byte_ready", 128'(ifa.byte_ready), 128'd0);
    check("rst_busy", 128'(busy_a), 128'd0);
    check("rst_done", 128'(done_a), 128'd0);
    check("rst_b_cdw_out", 128'(ifb.cdw_out), 128'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table jobs: full-rate with continuous bytes, then random stalls and byte gaps.
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 4; k++) job_bytes[k] = vecs[4 * j + k].b;
      run_job_a(100, 1'b1, 1'b1);
    end
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 4; k++) job_bytes[k] = vecs[4 * j + k].b;
      run_job_a(30, j == 1, 1'b0);
    end

    // OUT_W=32, M=5, single byte 0x81: 20 words of 0x55555555; byte_valid left high.
    ifb.byte_valid = 1'b1; ifb.byte_in = 8'h81; ifb.cdw_ready = 1'b1;
    start_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_b = 1'b0;
    wi = 0; bi = 0; last_x = -10; got_done = 0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      #1;
      if (done_b) begin
        check("b_done_timing", 128'(c), 128'(last_x + 1));
        check("b_word_count", 128'(wi), 128'd20);
        got_done = 1;
      end else begin
        if (bi == 1) check("b_byte_ready_low", 128'(ifb.byte_ready), 128'd0);
        if (ifb.cdw_valid && ifb.cdw_ready) begin
          check("b_word", 128'(ifb.cdw_out), 128'h55555555);
          wi++;
          last_x = c;
        end
        if (ifb.byte_valid && ifb.byte_ready) bi++;
        @(negedge clk);
      end
    end
    if (!got_done) check("b_timeout", 128'(got_done), 128'd1);
    ifb.byte_valid = 1'b0;
    @(negedge clk);

    // Reset after the fifth word of a job, then a fresh job must be clean.
    for (int k = 0; k < 4; k++) job_bytes[k] = vecs[k].b;
    ifa.cdw_ready = 1'b1;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    wi = 0; bi = 0;
    for (int c = 0; c < 50 && wi < 5; c++) begin
      ifa.byte_valid = (bi < 4);
      ifa.byte_in    = job_bytes[bi % 4];
      #1;
      if (ifa.cdw_valid && ifa.cdw_ready) wi++;
      if (ifa.byte_valid && ifa.byte_ready) bi++;
      @(negedge clk);
    end
    check("rst_mid_words", 128'(wi), 128'd5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mid_rst_cdw_out", ifa.cdw_out, 128'h0);
    check("mid_rst_cdw_valid", 128'(ifa.cdw_valid), 128'd0);
    check("mid_rst_byte_ready", 128'(ifa.byte_ready), 128'd0);
    check("mid_rst_busy", 128'(busy_a), 128'd0);
    check("mid_rst_done", 128'(done_a), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    ifa.byte_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_no_done", 128'(done_a), 128'd0);
      check("post_rst_idle", 128'(busy_a), 128'd0);
    end
    for (int k = 0; k < 4; k++) job_bytes[k] = vecs[4 + k].b;
    run_job_a(100, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
